vga_line_fetch: RTL and testbench

Pixel source stage feeding the VGA timing controller's `iRed`/`iGreen`/`iBlue` inputs. It fetches a 320x240 RGB444 framebuffer from external memory over a request/acknowledge read port into two on-chip line buffers, then serves each pixel to the controller at 2x horizontal and vertical upscale (640x480 active). It takes the controller's `oCoord_X`/`oCoord_Y` as its display coordinates and prefetches one source line ahead of the display.

---
 rtl/vga_line_fetch.sv | 177 +++++++++++++++++
 tb/tb_vga_line_fetch.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch.sv
// Double-buffered line fetcher: pulls a 320x240 RGB444 frame from a req/ack memory
// port one line ahead of the display and serves it at 2x upscale.
module vga_line_fetch #(
  parameter int SRC_W  = 320,
  parameter int SRC_H  = 240,
  parameter int ADDR_W = 17,
  parameter int RES    = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [9:0]        iCoord_X,
  input  logic [9:0]        iCoord_Y,
  input  logic              iFrame_Start,
  output logic              oMem_Req,
  output logic [ADDR_W-1:0] oMem_Addr,
  input  logic              iMem_Ack,
  input  logic              iMem_Valid,
  input  logic [3*RES-1:0]  iMem_Data,
  output logic [RES-1:0]    oRed,
  output logic [RES-1:0]    oGreen,
  output logic [RES-1:0]    oBlue,
  output logic              oUnderrun
);

  localparam int XW = $clog2(SRC_W);
  localparam int DW = 3 * RES;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q;
  logic [7:0]        line_q;
  logic [XW-1:0]     x_q;
  logic [ADDR_W-1:0] addr_q;
  logic              req_q;
  logic              abort_q;
  logic              pend_q;
  logic [7:0]        pendLine_q;
  logic              chain_q;
  logic [1:0]        tagVld_q;
  logic [7:0]        tagLine_q [2];
  logic [8:0]        prevS_q;

  logic [DW-1:0]     buf0 [SRC_W];
  logic [DW-1:0]     buf1 [SRC_W];

  logic [8:0]        xS1_q, sS1_q;
  logic              act1_q, act2_q, hit2_q;
  logic [DW-1:0]     rdWord_q;
  logic [DW-1:0]     rgb_q;
  logic              underrun_q;

  logic [8:0]        s;
  logic [9:0]        sPlus1;
  logic              newJob;
  logic [7:0]        jobLine;
  logic              wrEn;
  logic [XW-1:0]     rdIdx;

  assign s       = iCoord_Y[9:1];
  assign sPlus1  = {1'b0, s} + 10'd1;
  assign newJob  = (s != prevS_q) && (sPlus1 < 10'(SRC_H));
  assign jobLine = iFrame_Start ? 8'd0 : pendLine_q;
  assign wrEn    = (state_q == WAIT) && iMem_Valid && !abort_q && !iFrame_Start;
  assign rdIdx   = (xS1_q < 9'(SRC_W)) ? XW'(xS1_q) : '0;

  // Fetch FSM plus the single-entry job slot; a frame start lets the in-flight
  // word finish, discards it, then restarts at line 0.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= IDLE;
      line_q     <= '0;
      x_q        <= '0;
      addr_q     <= '0;
      req_q      <= 1'b0;
      abort_q    <= 1'b0;
      pend_q     <= 1'b0;
      pendLine_q <= '0;
      chain_q    <= 1'b0;
      tagVld_q   <= '0;
      tagLine_q  <= '{default: '0};
      prevS_q    <= '0;
    end else begin
      prevS_q <= s;
      case (state_q)
        IDLE: begin
          if (iFrame_Start || pend_q) begin
            line_q             <= jobLine;
            x_q                <= '0;
            addr_q             <= ADDR_W'(jobLine) * ADDR_W'(SRC_W);
            tagVld_q[jobLine[0]] <= 1'b0;
            req_q              <= 1'b1;
            pend_q             <= 1'b0;
            abort_q            <= 1'b0;
            state_q            <= REQ;
          end
        end
        REQ: begin
          if (iMem_Ack) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (iMem_Valid) begin
            if (abort_q || iFrame_Start) begin
              abort_q <= 1'b0;
              state_q <= IDLE;
            end else if (x_q == XW'(SRC_W - 1)) begin
              tagVld_q[line_q[0]]  <= 1'b1;
              tagLine_q[line_q[0]] <= line_q;
              state_q              <= IDLE;
              if (chain_q && line_q == 8'd0) begin
                pend_q     <= 1'b1;
                pendLine_q <= 8'd1;
                chain_q    <= 1'b0;
              end
            end else begin
              x_q     <= x_q + 1'b1;
              addr_q  <= addr_q + 1'b1;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (iFrame_Start) begin
        chain_q <= 1'b1;
        if (state_q != IDLE) begin
          pend_q     <= 1'b1;
          pendLine_q <= 8'd0;
          abort_q    <= 1'b1;
        end
      end else if (newJob) begin
        pend_q     <= 1'b1;
        pendLine_q <= sPlus1[7:0];
      end
    end
  end

  // Line buffer storage: one write port from the fetcher, one read port for display.
  always_ff @(posedge iCLK) begin
    if (wrEn && !line_q[0]) buf0[x_q] <= iMem_Data;
    if (wrEn && line_q[0])  buf1[x_q] <= iMem_Data;
    rdWord_q <= sS1_q[0] ? buf1[rdIdx] : buf0[rdIdx];
  end

  // Three-stage display path; coordinates outside 640x480 are blanking and never
  // count as stale reads.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      xS1_q      <= '0;
      sS1_q      <= '0;
      act1_q     <= 1'b0;
      act2_q     <= 1'b0;
      hit2_q     <= 1'b0;
      rgb_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      xS1_q  <= iCoord_X[9:1];
      sS1_q  <= s;
      act1_q <= (iCoord_X < 10'(2 * SRC_W)) && (iCoord_Y < 10'(2 * SRC_H));
      act2_q <= act1_q;
      hit2_q <= tagVld_q[sS1_q[0]] && ({1'b0, tagLine_q[sS1_q[0]]} == sS1_q);
      rgb_q  <= (act2_q && hit2_q) ? rdWord_q : '0;
      if (act2_q && !hit2_q) underrun_q <= 1'b1;
    end
  end

  assign oMem_Req  = req_q;
  assign oMem_Addr = addr_q;
  assign oRed      = rgb_q[DW-1 -: RES];
  assign oGreen    = rgb_q[2*RES-1 -: RES];
  assign oBlue     = rgb_q[RES-1:0];
  assign oUnderrun = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch.sv
// Bench for vga_line_fetch: one cycle-stepping task drives coordinates and a
// req/ack memory model; expected pixels and addresses are queued and compared later.
module tb_vga_line_fetch;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [9:0]  iCoord_X, iCoord_Y;
  logic        iFrame_Start;
  logic        oMem_Req;
  logic [16:0] oMem_Addr;
  logic        iMem_Ack, iMem_Valid;
  logic [11:0] iMem_Data;
  logic [3:0]  oRed, oGreen, oBlue;
  logic        oUnderrun;

  vga_line_fetch dut (
    .iCLK(iCLK), .iRST(iRST), .iCoord_X(iCoord_X), .iCoord_Y(iCoord_Y),
    .iFrame_Start(iFrame_Start), .oMem_Req(oMem_Req), .oMem_Addr(oMem_Addr),
    .iMem_Ack(iMem_Ack), .iMem_Valid(iMem_Valid), .iMem_Data(iMem_Data),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oUnderrun(oUnderrun)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    bit          chk;
    logic [11:0] rgb;
    bit          und;
  } dispEnt_t;

  dispEnt_t dispQ [$];
  int       addrQ [$];
  int       checks = 0;
  int       errors = 0;

  int          wantX, wantY;
  bit          wantChk, wantUnd, fsWant, ackEn, acked;
  logic [11:0] wantRgb;
  int          vldCnt = 0, vldAddr = 0, ackCount = 0;

  function automatic logic [11:0] memWord(input int a);
    if (a == 2) return 12'hA5C;
    return 12'((a * 29 + 17) ^ (a >> 3));
  endfunction

  function automatic logic [11:0] expPix(input int x, input int y);
    return memWord((y / 2) * 320 + x / 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One pixel clock: score the pixel driven three negedges ago, run the memory
  // model, then drive this cycle's inputs and queue their expectation.
  task automatic cycle();
    dispEnt_t e;
    @(negedge iCLK);
    if (dispQ.size() >= 3) begin
      e = dispQ.pop_front();
      if (e.chk) begin
        checkOutput("pixel_rgb", {20'd0, oRed, oGreen, oBlue}, {20'd0, e.rgb});
        checkOutput("underrun", {31'd0, oUnderrun}, {31'd0, e.und});
      end
    end
    iMem_Valid = 1'b0;
    iMem_Ack   = 1'b0;
    acked      = 1'b0;
    if (vldCnt > 0) begin
      vldCnt--;
      if (vldCnt == 0) begin
        iMem_Valid = 1'b1;
        iMem_Data  = memWord(vldAddr);
      end
    end
    if (ackEn && oMem_Req && vldCnt == 0 && !iMem_Valid) begin
      iMem_Ack = 1'b1;
      vldAddr  = int'(oMem_Addr);
      vldCnt   = 2;
      acked    = 1'b1;
      ackCount++;
      if (addrQ.size() > 0) checkOutput("mem_addr", {15'd0, oMem_Addr}, addrQ.pop_front());
    end
    iFrame_Start = fsWant;
    fsWant       = 1'b0;
    iCoord_X     = 10'(wantX);
    iCoord_Y     = 10'(wantY);
    dispQ.push_back('{wantChk, wantRgb, wantUnd});
  endtask

  task automatic applyStimulus(input int x, input int y, input bit chk,
                               input logic [11:0] rgb, input bit und);
    wantX = x; wantY = y; wantChk = chk; wantRgb = rgb; wantUnd = und;
    cycle();
  endtask

  task automatic waitIdle(input int budget);
    int run = 0;
    for (int i = 0; i < budget && run < 8; i++) begin
      cycle();
      run = (!oMem_Req && vldCnt == 0) ? run + 1 : 0;
    end
    checkOutput("fetch_idle", run, 8);
  endtask

  initial begin
    iRST = 1'b1; iFrame_Start = 1'b0; iMem_Ack = 1'b0; iMem_Valid = 1'b0;
    iMem_Data = '0; iCoord_X = 10'd1023; iCoord_Y = 10'd1023;
    fsWant = 1'b0; ackEn = 1'b1;

    repeat (3) applyStimulus(1023, 1023, 0, 12'h0, 0);
    checkOutput("rst_req", {31'd0, oMem_Req}, 0);
    checkOutput("rst_addr", {15'd0, oMem_Addr}, 0);
    checkOutput("rst_rgb", {20'd0, oRed, oGreen, oBlue}, 0);
    checkOutput("rst_underrun", {31'd0, oUnderrun}, 0);
    iRST = 1'b0;
    repeat (2) applyStimulus(1023, 1023, 1, 12'h0, 0);

    $display("[TB] frame start fetch of lines 0 and 1");
    for (int a = 0; a < 640; a++) addrQ.push_back(a);
    fsWant = 1'b1;
    applyStimulus(1023, 1023, 1, 12'h0, 0);
    waitIdle(4000);
    checkOutput("frame_addr_left", addrQ.size(), 0);

    $display("[TB] pixel serve");
    applyStimulus(4, 0, 1, 12'hA5C, 0);
    applyStimulus(5, 0, 1, 12'hA5C, 0);
    for (int x = 0; x < 640; x += 37) applyStimulus(x, 0, 1, expPix(x, 0), 0);
    applyStimulus(639, 0, 1, expPix(639, 0), 0);
    waitIdle(3000);

    $display("[TB] line advance and underrun");
    for (int i = 0; i < 4; i++) applyStimulus(i * 50, 1, 1, expPix(i * 50, 1), 0);
    for (int a = 640; a < 960; a++) addrQ.push_back(a);
    ackCount = 0;
    for (int i = 0; i < 600 && ackCount < 20; i++)
      applyStimulus((i * 16) % 640, 2 + (i % 2), 1, expPix((i * 16) % 640, 2), 0);
    checkOutput("line2_started", {31'd0, ackCount >= 20}, 1);
    ackEn = 1'b0;
    for (int i = 0; i < 2000; i++) applyStimulus((i * 7) % 640, 3, 1, expPix((i * 7) % 640, 3), 0);
    checkOutput("stall_req", {31'd0, oMem_Req}, 1);
    checkOutput("stall_addr", {15'd0, oMem_Addr}, 660);
    for (int i = 0; i < 10; i++) applyStimulus(i * 20, 4, 1, 12'h0, 1);
    ackEn = 1'b1;
    applyStimulus(100, 4, 0, 12'h0, 1);
    waitIdle(4000);
    checkOutput("line2_addr_left", addrQ.size(), 0);
    for (int x = 0; x < 640; x += 53) applyStimulus(x, 4, 1, expPix(x, 4), 1);

    $display("[TB] frame start mid-fetch");
    applyStimulus(0, 8, 0, 12'h0, 1);
    for (int i = 0; i < 3000 && !(acked && vldAddr == 1700); i++) cycle();
    checkOutput("saw_x100", vldAddr, 1700);
    for (int a = 0; a < 640; a++) addrQ.push_back(a);
    fsWant = 1'b1;
    cycle();
    waitIdle(5000);
    checkOutput("restart_addr_left", addrQ.size(), 0);
    for (int i = 0; i < 5; i++) applyStimulus(i * 100, 8, 1, 12'h0, 1);

    $display("[TB] reset mid-fetch");
    applyStimulus(0, 0, 0, 12'h0, 1);
    for (int i = 0; i < 50 && !acked; i++) cycle();
    checkOutput("pre_reset_req", {31'd0, acked}, 1);
    iRST = 1'b1;
    #1;
    checkOutput("async_req_drop", {31'd0, oMem_Req}, 0);
    checkOutput("async_rgb", {20'd0, oRed, oGreen, oBlue}, 0);
    checkOutput("async_underrun", {31'd0, oUnderrun}, 0);
    ackEn = 1'b0;
    cycle();
    iRST = 1'b0;
    cycle();
    for (int i = 0; i < 6; i++) applyStimulus(i * 30, 0, 1, 12'h0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(i * 30, 2, 1, 12'h0, 1);
    checkOutput("post_reset_req", {31'd0, oMem_Req}, 1);
    checkOutput("post_reset_addr", {15'd0, oMem_Addr}, 640);
    repeat (3) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
